ysyx_24100029_axi_sram: RTL and testbench

//  AXI4 responder (slave) backed by a word-addressed SRAM array; the memory end that answers the
//  LSU/IFU masters in simulation and on the NPC bus. One outstanding transaction at a time; FIXED,

---
 rtl/ysyx_24100029_axi_pkg.sv | 51 +++++
 rtl/ysyx_24100029_axi_sram_if.sv | 64 ++++++
 rtl/ysyx_24100029_axi_delay_cnt.sv | 42 ++++
 rtl/ysyx_24100029_axi_sram.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ysyx_24100029_axi_sram.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100029_axi_pkg.sv
// ysyx_24100029_axi_pkg
//   Shared AXI4 encodings, bus widths, the SRAM responder state type and the
//   burst address-advance helper used by the SRAM responder.
//   No ports (package).
package ysyx_24100029_axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_DATA,
        S_WR_DATA,
        S_WR_WAIT,
        S_WR_RESP
    } sram_state_e;

    // Address of the next beat. WRAP keeps the upper bits of the
    // (len+1)<<size aligned window and lets only the in-window offset roll over.
    // The reserved encoding 2'b11 is treated like INCR.
    function automatic logic [AXI_ADDR_W-1:0] axiNextAddr(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [AXI_ADDR_W-1:0] step;
        logic [AXI_ADDR_W-1:0] mask;
        logic [AXI_ADDR_W-1:0] incAddr;
        logic [AXI_ADDR_W-1:0] result;
        step    = AXI_ADDR_W'(1) << size;
        mask    = ((AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size) - AXI_ADDR_W'(1);
        incAddr = addr + step;
        case (burst)
            BURST_FIXED: result = addr;
            BURST_WRAP:  result = (addr & ~mask) | (incAddr & mask);
            default:     result = incAddr;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ysyx_24100029_axi_sram_if.sv
// ysyx_24100029_axi_sram_if
//   AXI4 channel bundle between one master (LSU/IFU or a bench) and the SRAM
//   responder. Clock and reset are not part of the bundle.
//   Modports:
//     master : drives AW/W/AR payload+valid and bready/rready
//     slave  : drives awready/wready/arready and the B and R channels
interface ysyx_24100029_axi_sram_if;
    import ysyx_24100029_axi_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_ID_W-1:0]   awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [AXI_ID_W-1:0]   bid;

    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_ID_W-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [AXI_ID_W-1:0]   rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );

endinterface

// File: rtl/ysyx_24100029_axi_delay_cnt.sv
// ysyx_24100029_axi_delay_cnt
//   Response-latency counter shared by the read and write paths.
//   Ports:
//     clock    in  rising-edge clock
//     reset    in  asynchronous, active-low
//     i_start  in  load i_load and begin counting
//     i_load   in  number of wait cycles
//     o_done   out one-cycle pulse when the wait is over; same cycle as
//                  i_start when i_load is zero
module ysyx_24100029_axi_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_start,
    input  logic [W-1:0] i_load,
    output logic         o_done
);

    logic [W-1:0] r_cnt;
    logic         r_busy;

    // Storing load-1 makes done fire on the last of the i_load wait cycles.
    assign o_done = (i_start && (i_load == '0)) || (r_busy && (r_cnt == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start && (i_load != '0)) begin
            r_cnt  <= i_load - 1'b1;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_24100029_axi_sram.sv
// ysyx_24100029_axi_sram
//   AXI4 responder backed by a word-addressed SRAM array. One transaction at a
//   time, FIXED/INCR/WRAP bursts up to 256 beats, byte-strobed writes,
//   SLVERR for out-of-range beats or wlast mismatch. Read wins over write when
//   both address channels are valid in IDLE.
//   Ports:
//     clock  in  rising-edge clock
//     reset  in  asynchronous, active-low
//     axi    slave side of ysyx_24100029_axi_sram_if
//   Build option:
//     YSYX_24100029_AXI_SRAM_RAND_DELAY_EN - wait length taken from the low
//     3 bits of a free-running LFSR instead of DELAY.
module ysyx_24100029_axi_sram
    import ysyx_24100029_axi_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                DELAY      = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    ysyx_24100029_axi_sram_if.slave     axi
);

    localparam int                WORDS = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(WORDS) << 2;

    logic [DATA_W-1:0] r_mem [WORDS];

    sram_state_e       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_id;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;
    logic              r_err;

    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic [3:0]        r_rid;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [3:0]        r_bid;
    logic              r_wready;

    logic              w_arFire;
    logic              w_awFire;
    logic              w_rFire;
    logic              w_wFire;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_rdHit;
    logic [DATA_W-1:0] w_rdWord;
    logic [1:0]        w_rdResp;
    logic              w_wrHit;
    logic              w_wrLast;
    logic              w_errNext;
    logic              w_dlyStart;
    logic [7:0]        w_dlyLoad;
    logic              w_dlyDone;

    // Unsigned subtraction wraps addresses below BASE_ADDR to huge offsets,
    // so a single compare covers both range ends.
    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] wordIdx(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

    assign axi.arready = (r_state == S_IDLE);
    assign axi.awready = (r_state == S_IDLE) && !axi.arvalid;
    assign axi.wready  = r_wready;
    assign axi.rvalid  = r_rvalid;
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;
    assign axi.rlast   = r_rlast;
    assign axi.rid     = r_rid;
    assign axi.bvalid  = r_bvalid;
    assign axi.bresp   = r_bresp;
    assign axi.bid     = r_bid;

    assign w_arFire   = axi.arvalid && (r_state == S_IDLE);
    assign w_awFire   = axi.awvalid && (r_state == S_IDLE) && !axi.arvalid;
    assign w_rFire    = r_rvalid && axi.rready;
    assign w_wFire    = axi.wvalid && r_wready;
    assign w_nextAddr = axiNextAddr(r_addr, r_size, r_len, r_burst);

    // The word loaded into rdata: the incoming araddr on a zero-latency
    // accept, the latched start address after a wait, the next beat's
    // address while streaming.
    always_comb begin
        w_rdAddr = r_addr;
        case (r_state)
            S_IDLE:    w_rdAddr = axi.araddr;
            S_RD_DATA: w_rdAddr = w_nextAddr;
            default:   w_rdAddr = r_addr;
        endcase
    end

    assign w_rdHit  = inRange(w_rdAddr);
    assign w_rdWord = w_rdHit ? r_mem[wordIdx(w_rdAddr)] : '0;
    assign w_rdResp = w_rdHit ? RESP_OKAY : RESP_SLVERR;

    assign w_wrHit   = inRange(r_addr);
    assign w_wrLast  = (r_cnt == r_len);
    assign w_errNext = r_err || !w_wrHit || (axi.wlast != w_wrLast);

    assign w_dlyStart = w_arFire || (w_wFire && w_wrLast);

`ifdef YSYX_24100029_AXI_SRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, free-running from reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_dlyLoad = {5'd0, r_lfsr[2:0]};
`else
    assign w_dlyLoad = 8'(DELAY);
`endif

    ysyx_24100029_axi_delay_cnt #(
        .W (8)
    ) u_delay (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_dlyStart),
        .i_load  (w_dlyLoad),
        .o_done  (w_dlyDone)
    );

    // Array contents survive reset; out-of-range beats are dropped.
    always_ff @(posedge clock) begin
        if (w_wFire && w_wrHit) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (axi.wstrb[b]) begin
                    r_mem[wordIdx(r_addr)][8*b +: 8] <= axi.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_id     <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_bid    <= '0;
            r_wready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arFire) begin
                        r_addr  <= axi.araddr;
                        r_id    <= axi.arid;
                        r_len   <= axi.arlen;
                        r_size  <= axi.arsize;
                        r_burst <= axi.arburst;
                        r_cnt   <= '0;
                        if (w_dlyDone) begin
                            r_state  <= S_RD_DATA;
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_rdWord;
                            r_rresp  <= w_rdResp;
                            r_rid    <= axi.arid;
                            r_rlast  <= (axi.arlen == 8'd0);
                        end else begin
                            r_state <= S_RD_WAIT;
                        end
                    end else if (w_awFire) begin
                        r_addr   <= axi.awaddr;
                        r_id     <= axi.awid;
                        r_len    <= axi.awlen;
                        r_size   <= axi.awsize;
                        r_burst  <= axi.awburst;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                        r_wready <= 1'b1;
                        r_state  <= S_WR_DATA;
                    end
                end
                S_RD_WAIT: begin
                    if (w_dlyDone) begin
                        r_state  <= S_RD_DATA;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_rdWord;
                        r_rresp  <= w_rdResp;
                        r_rid    <= r_id;
                        r_rlast  <= (r_len == 8'd0);
                    end
                end
                S_RD_DATA: begin
                    if (w_rFire) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_addr  <= w_nextAddr;
                            r_cnt   <= r_cnt + 8'd1;
                            r_rdata <= w_rdWord;
                            r_rresp <= w_rdResp;
                            r_rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_wFire) begin
                        r_err <= w_errNext;
                        if (w_wrLast) begin
                            r_wready <= 1'b0;
                            if (w_dlyDone) begin
                                r_state  <= S_WR_RESP;
                                r_bvalid <= 1'b1;
                                r_bresp  <= w_errNext ? RESP_SLVERR : RESP_OKAY;
                                r_bid    <= r_id;
                            end else begin
                                r_state <= S_WR_WAIT;
                            end
                        end else begin
                            r_addr <= w_nextAddr;
                            r_cnt  <= r_cnt + 8'd1;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (w_dlyDone) begin
                        r_state  <= S_WR_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
                        r_bid    <= r_id;
                    end
                end
                S_WR_RESP: begin
                    if (axi.bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_axi_sram.sv
// tb_ysyx_24100029_axi_sram
//   Directed bench for the AXI SRAM responder built with DELAY=3. Expected
//   read beats and write responses come from a bench-side memory model and
//   are queued when a transaction is issued, then popped as the DUT answers.
module tb_ysyx_24100029_axi_sram;
    import ysyx_24100029_axi_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          DLY  = 3;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rdExp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bExp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rdExp_t      rdQ[$];
    bExp_t       bQ[$];
    logic [31:0] mdl[int];

    ysyx_24100029_axi_sram_if axi ();

    ysyx_24100029_axi_sram #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH_LOG2 (12),
        .BASE_ADDR  (BASE),
        .DELAY      (DLY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .axi   (axi)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case some bounded wait is mis-sized.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit inRange(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h0000_4000);
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'h0000_0FFF);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (!inRange(a)) return 32'h0;
        if (mdl.exists(idxOf(a))) return mdl[idxOf(a)];
        return 32'h0;
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] w;
        w = mdl.exists(idxOf(a)) ? mdl[idxOf(a)] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mdl[idxOf(a)] = w;
    endtask

    // Burst address sequence written as offsets into the wrap window.
    function automatic logic [31:0] nextAddr(input logic [31:0] a, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] bytes;
        logic [31:0] win;
        logic [31:0] start;
        bytes = 32'd1 << size;
        win   = ({24'd0, len} + 32'd1) * bytes;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            start = a - (a % win);
            return start + ((a - start + bytes) % win);
        end
        return a + bytes;
    endfunction

    task automatic popRead(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        rdExp_t e;
        if (rdQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL rd_unexpected observed=%h expected=none", d);
        end else begin
            e = rdQ.pop_front();
            checkOutput("rd_data", d, e.data);
            checkOutput("rd_resp", 32'(r), 32'(e.resp));
            checkOutput("rd_last", 32'(l), 32'(e.last));
            checkOutput("rd_id", 32'(id), 32'(e.id));
        end
    endtask

    task automatic popB(input logic [1:0] r, input logic [3:0] id);
        bExp_t e;
        if (bQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL b_unexpected observed=%h expected=none", r);
        end else begin
            e = bQ.pop_front();
            checkOutput("b_resp", 32'(r), 32'(e.resp));
            checkOutput("b_id", 32'(id), 32'(e.id));
        end
    endtask

    task automatic pushReads(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            rdQ.push_back('{modelRead(a), inRange(a) ? 2'b00 : 2'b10, (i == int'(len)), id});
            a = nextAddr(a, size, len, burst);
        end
    endtask

    // Beat data is d0 + i*0x1111_1111. wlast is inverted on beat badBeat.
    task automatic writeBurst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                              input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                              input int badBeat);
        logic [31:0] a;
        logic        err;
        logic        lastBit;
        logic [1:0]  br;
        logic [3:0]  bi;
        int          cyc;
        int          lat;
        a   = addr;
        err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            lastBit = (i == int'(len)) ^ (i == badBeat);
            if (!inRange(a)) err = 1'b1;
            else modelWrite(a, d0 + 32'(i) * 32'h1111_1111, strb);
            if (lastBit != (i == int'(len))) err = 1'b1;
            a = nextAddr(a, 3'd2, len, burst);
        end
        bQ.push_back('{err ? 2'b10 : 2'b00, id});

        axi.awaddr  = addr;
        axi.awid    = id;
        axi.awlen   = len;
        axi.awsize  = 3'd2;
        axi.awburst = burst;
        axi.awvalid = 1'b1;
        #1;
        cyc = 0;
        while (!axi.awready && cyc < 100) begin
            step();
            cyc++;
        end
        checkOutput("aw_timeout", 32'(cyc < 100), 32'd1);
        step();
        axi.awvalid = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            axi.wvalid = 1'b1;
            axi.wdata  = d0 + 32'(i) * 32'h1111_1111;
            axi.wstrb  = strb;
            axi.wlast  = (i == int'(len)) ^ (i == badBeat);
            cyc = 0;
            while (!axi.wready && cyc < 100) begin
                step();
                cyc++;
            end
            checkOutput("w_timeout", 32'(cyc < 100), 32'd1);
            step();
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;

        lat = 1;
        while (!axi.bvalid && lat < 100) begin
            step();
            lat++;
        end
        checkOutput("wr_latency", 32'(lat), 32'(DLY + 1));
        axi.bready = 1'b1;
        br = axi.bresp;
        bi = axi.bid;
        step();
        axi.bready = 1'b0;
        popB(br, bi);
    endtask

    // rready for the k-th cycle with rvalid high is stallPat[k%8].
    task automatic readBurst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [7:0] stallPat);
        int          cyc;
        int          lat;
        int          beats;
        int          k;
        logic        v;
        logic        rdy;
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        logic [3:0]  ri;
        logic        holdValid;
        logic [31:0] holdData;
        pushReads(addr, id, len, size, burst);

        axi.araddr  = addr;
        axi.arid    = id;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        #1;
        cyc = 0;
        while (!axi.arready && cyc < 100) begin
            step();
            cyc++;
        end
        checkOutput("ar_timeout", 32'(cyc < 100), 32'd1);
        step();
        axi.arvalid = 1'b0;

        lat = 1;
        while (!axi.rvalid && lat < 100) begin
            step();
            lat++;
        end
        checkOutput("rd_latency", 32'(lat), 32'(DLY + 1));

        beats     = 0;
        cyc       = 0;
        k         = 0;
        holdValid = 1'b0;
        holdData  = 32'h0;
        while (beats <= int'(len) && cyc < 600) begin
            v   = axi.rvalid;
            rdy = v ? stallPat[k % 8] : 1'b0;
            if (v) k++;
            axi.rready = rdy;
            d  = axi.rdata;
            r  = axi.rresp;
            l  = axi.rlast;
            ri = axi.rid;
            if (v && holdValid) begin
                checkOutput("rd_stall_hold", d, holdData);
                holdValid = 1'b0;
            end
            if (v && !rdy) begin
                holdValid = 1'b1;
                holdData  = d;
            end
            step();
            if (v && rdy) begin
                popRead(d, r, l, ri);
                beats++;
            end
            cyc++;
        end
        axi.rready = 1'b0;
        checkOutput("rd_beats", 32'(beats), 32'(int'(len) + 1));
    endtask

    initial begin
        int          cyc;
        logic        sawAw;
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        logic [3:0]  ri;
        checks = 0;
        errors = 0;
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.awid = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = '0; axi.arid = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.rready  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_rvalid", 32'(axi.rvalid), 32'd0);
        checkOutput("rst_bvalid", 32'(axi.bvalid), 32'd0);
        checkOutput("rst_wready", 32'(axi.wready), 32'd0);
        checkOutput("rst_rlast", 32'(axi.rlast), 32'd0);
        checkOutput("rst_rdata", axi.rdata, 32'd0);
        checkOutput("rst_bresp", 32'(axi.bresp), 32'd0);
        reset = 1'b1;
        step();
        checkOutput("rst_arready", 32'(axi.arready), 32'd1);
        checkOutput("rst_awready", 32'(axi.awready), 32'd1);

        $display("[TB] single strobed write");
        writeBurst(32'h8000_0004, 4'h3, 8'd0, BURST_FIXED, 32'hFFFF_FFFF, 4'hF, -1);
        writeBurst(32'h8000_0004, 4'h9, 8'd0, BURST_FIXED, 32'h1122_3344, 4'b0100, -1);
        readBurst(32'h8000_0004, 4'h2, 8'd0, 3'd2, BURST_INCR, 8'hFF);

        $display("[TB] INCR read with rready stalls");
        writeBurst(32'h8000_0010, 4'h1, 8'd3, BURST_INCR, 32'hA0A0_0000, 4'hF, -1);
        readBurst(32'h8000_0010, 4'h5, 8'd3, 3'd2, BURST_INCR, 8'h55);

        $display("[TB] simultaneous AR and AW");
        axi.awaddr = 32'h8000_0008; axi.awid = 4'hB; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = BURST_INCR;
        axi.awvalid = 1'b1;
        axi.araddr = 32'h8000_0010; axi.arid = 4'hC; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = BURST_INCR;
        axi.arvalid = 1'b1;
        pushReads(32'h8000_0010, 4'hC, 8'd0, 3'd2, BURST_INCR);
        #1;
        checkOutput("t3_arready", 32'(axi.arready), 32'd1);
        checkOutput("t3_awready", 32'(axi.awready), 32'd0);
        step();
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        sawAw = 1'b0;
        cyc = 0;
        while (!axi.rvalid && cyc < 100) begin
            if (axi.awready) sawAw = 1'b1;
            step();
            cyc++;
        end
        checkOutput("t3_r_timeout", 32'(cyc < 100), 32'd1);
        if (axi.awready) sawAw = 1'b1;
        d = axi.rdata; r = axi.rresp; l = axi.rlast; ri = axi.rid;
        step();
        popRead(d, r, l, ri);
        axi.rready = 1'b0;
        checkOutput("t3_aw_held_off", 32'(sawAw), 32'd0);
        checkOutput("t3_awready_after", 32'(axi.awready), 32'd1);
        writeBurst(32'h8000_0008, 4'hB, 8'd0, BURST_INCR, 32'h5555_AAAA, 4'hF, -1);
        readBurst(32'h8000_0008, 4'hD, 8'd0, 3'd2, BURST_INCR, 8'hFF);

        $display("[TB] error responses");
        writeBurst(32'h8000_0000, 4'h4, 8'd0, BURST_INCR, 32'hCAFE_0000, 4'hF, -1);
        readBurst(32'h7FFF_FFFC, 4'h6, 8'd0, 3'd2, BURST_INCR, 8'hFF);
        writeBurst(32'h8000_4000, 4'h7, 8'd0, BURST_INCR, 32'hDEAD_BEEF, 4'hF, -1);
        readBurst(32'h8000_0000, 4'h6, 8'd0, 3'd2, BURST_INCR, 8'hFF);
        writeBurst(32'h8000_0020, 4'h8, 8'd1, BURST_INCR, 32'h1234_0000, 4'hF, 0);

        $display("[TB] reset during read data");
        axi.araddr = 32'h8000_0010; axi.arid = 4'h5; axi.arlen = 8'd3; axi.arsize = 3'd2; axi.arburst = BURST_INCR;
        axi.arvalid = 1'b1;
        #1;
        cyc = 0;
        while (!axi.arready && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        axi.arvalid = 1'b0;
        cyc = 1;
        while (!axi.rvalid && cyc < 100) begin
            step();
            cyc++;
        end
        checkOutput("t5_latency", 32'(cyc), 32'd4);
        reset = 1'b0;
        #1;
        checkOutput("t5_rvalid_in_reset", 32'(axi.rvalid), 32'd0);
        step();
        step();
        #2;
        reset = 1'b1;
        step();
        checkOutput("t5_arready_after", 32'(axi.arready), 32'd1);
        readBurst(32'h8000_0010, 4'h5, 8'd3, 3'd2, BURST_INCR, 8'hFF);

        $display("[TB] WRAP read");
        readBurst(32'h8000_0018, 4'hA, 8'd3, 3'd2, BURST_WRAP, 8'hFF);

        checkOutput("rdq_empty", 32'(rdQ.size()), 32'd0);
        checkOutput("bq_empty", 32'(bQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
